lottery_draw: RTL and testbench
===============================

Name: lottery_draw

Overview:
- Sequential producer of the four lottery winning numbers: the drawing end of the W1..W4/SYSRDY interface.
- On START, steps a free-running 16-bit LFSR and draws four distinct non-zero numbers into W1..W4, rejecting invalid candidates.
- Then raises SYSRDY, holding the same validity guarantee the ticket-checking logic expects: all non-zero, all pairwise distinct.
- Sits between the operator START button and the winning-number consumers; replaces the hard-wired numbers.

Parameters:
- NUM_W, 5, width of each winning number (values 1..2^NUM_W-1).
- MAX_NUM, 31, largest legal number; candidates above it are rejected.
- SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- START  input  1  level; sampled on CLK in IDLE only, requests a new draw.
- W1  output  NUM_W  first winning number.
- W2  output  NUM_W  second winning number.
- W3  output  NUM_W  third winning number.
- W4  output  NUM_W  fourth winning number.
- BUSY  output  1  high while a draw is in progress (DRAW state).
- DONE  output  1  one-cycle pulse when the fourth number is stored.
- SYSRDY  output  1  high while W1..W4 hold a complete valid draw.

Behaviour:
- Reset (RST=1, async):
  - W1..W4=0, BUSY=0, DONE=0, SYSRDY=0.
  - LFSR=SEED, idx=0, state=IDLE.
  - Reset mid-draw aborts the draw; partial numbers are discarded.
- LFSR:
  - Fibonacci, right shift, steps every CLK edge in every state.
  - Feedback bit = l[0]^l[2]^l[3]^l[5], inserted at bit 15.
  - Candidate = l[NUM_W-1:0], taken from the current (pre-step) LFSR value.
- States: IDLE, DRAW, FIN; binary encoded.
- IDLE:
  - START=1 → clear W1..W4 to 0, SYSRDY=0, idx=0, go DRAW.
  - Otherwise hold. W1..W4 and SYSRDY keep their last values.
- DRAW (BUSY=1), once per cycle:
  - Candidate accepted iff: non-zero, ≤ MAX_NUM, and unequal to every already-stored W[0..idx-1].
  - Accept → W[idx] <= candidate, idx++.
  - Reject → nothing stored; retry next cycle with the next LFSR value.
  - When the accept stores index 3, go FIN.
- FIN (one cycle):
  - DONE=1, SYSRDY=1, BUSY=0; go IDLE.
  - SYSRDY stays 1 until the next accepted START or RST.
- Timing:
  - Minimum latency: START edge → DONE high = 5 cycles (4 DRAW + FIN).
  - Each rejected candidate adds exactly one cycle.
- START handling:
  - Ignored in DRAW and FIN.
  - Held high continuously, it re-triggers a new draw on the IDLE edge after FIN.
- Invariant: whenever SYSRDY=1, W1..W4 are all non-zero, pairwise distinct, and ≤ MAX_NUM.
- Compare/accept logic is combinational from registered W values; no combinational path from START to any output.

Decomposition:
- Package lottery_pkg holds:
  - NUM_W and NUM_COUNT=4.
  - State encoding constants IDLE/DRAW/FIN.
  - LFSR tap positions and default SEED.
- One sub-module: lfsr16.
  - Ports CLK, RST, q[15:0].
  - Async reset to SEED; steps every cycle.
- The FSM, the index counter and the distinctness comparators stay in lottery_draw.

Test Plan:
- Reset value: assert RST mid-cycle, no clock → all outputs 0 immediately. LFSR reads 16'hACE1 and steps to 16'h5670 after one edge with RST low.
- Deterministic draw:
  - Release reset, START=1 for the first edge → first DRAW candidate 16 (from 5670) gives W1=16.
  - Next candidate 24 (from AB38) gives W2=24.
  - W3/W4 match the bench model. DONE pulses exactly one cycle and SYSRDY rises with it.
- Rejection:
  - Force SEED so the first candidate is 0, then a value equal to W1 → both rejected, each adding one cycle.
  - DONE arrives after 7 cycles; final W values are distinct and non-zero.
- MAX_NUM=20 build: 1000 draws with random START spacing → no W value > 20 and no duplicates whenever SYSRDY=1.
- Reset mid-draw: RST asserted after W2 stored → W1..W4=0, SYSRDY=0, BUSY=0. The next START restarts from idx=0.
- START in DRAW ignored: pulse START during DRAW → DONE is a single pulse and no re-clear occurs. START held high → back-to-back draws, with SYSRDY dropping for one IDLE edge between them.

Source files
------------

// File: rtl/lottery_pkg.sv
// Shared constants for the lottery draw: number width, draw size, LFSR taps/seed, FSM encoding.
package lottery_pkg;

  localparam int NUM_W     = 5;
  localparam int NUM_COUNT = 4;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int TAP_A = 0;
  localparam int TAP_B = 2;
  localparam int TAP_C = 3;
  localparam int TAP_D = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Fibonacci right-shift step; feedback enters at bit 15.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D], l[15:1]};
  endfunction

endpackage

// File: rtl/lottery_draw_lfsr16.sv
// Free-running 16-bit LFSR; steps on every clock edge regardless of draw state.
module lfsr16 #(
  parameter logic [15:0] SEED = lottery_pkg::DEFAULT_SEED
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [15:0] q
);
  import lottery_pkg::*;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) q <= SEED;
    else     q <= lfsr_next(q);
  end

endmodule

// File: rtl/lottery_draw.sv
// Draws four distinct non-zero winning numbers from an LFSR on START, then raises SYSRDY.
// Handshake: START is a level sampled only in IDLE; DONE pulses for the single FIN cycle; SYSRDY holds until the next accepted START.
module lottery_draw #(
  parameter int          NUM_W   = lottery_pkg::NUM_W,
  parameter int          MAX_NUM = 31,
  parameter logic [15:0] SEED    = lottery_pkg::DEFAULT_SEED
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic [NUM_W-1:0] W1,
  output logic [NUM_W-1:0] W2,
  output logic [NUM_W-1:0] W3,
  output logic [NUM_W-1:0] W4,
  output logic             BUSY,
  output logic             DONE,
  output logic             SYSRDY,
  output logic [1:0]       dbg_state
);
  import lottery_pkg::*;

  state_t state, state_nxt;
  logic [15:0] lfsr_q;
  logic [NUM_COUNT-1:0][NUM_W-1:0] w_q;
  logic [1:0] idx;
  logic [NUM_W-1:0] cand;
  logic is_dup, accept, last_slot, rdy_q;
  logic unused_lfsr_hi;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .CLK (CLK),
    .RST (RST),
    .q   (lfsr_q)
  );

  assign cand           = lfsr_q[NUM_W-1:0];
  assign unused_lfsr_hi = ^lfsr_q[15:NUM_W];
  assign last_slot      = (idx == 2'(NUM_COUNT - 1));

  // Only slots already filled in this draw take part in the duplicate check.
  always_comb begin
    is_dup = 1'b0;
    for (int i = 0; i < NUM_COUNT; i++) begin
      if ((i < int'(idx)) && (w_q[i] == cand)) is_dup = 1'b1;
    end
  end

  assign accept = (state == DRAW) && (cand != '0) && (int'(cand) <= MAX_NUM) && !is_dup;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      IDLE: if (START) state_nxt = DRAW;
      DRAW: begin
        BUSY = 1'b1;
        if (accept && last_slot) state_nxt = FIN;
      end
      FIN: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SYSRDY rises on the same edge that stores the fourth number, so it is high alongside DONE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_q   <= '0;
      idx   <= '0;
      rdy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (START) begin
          w_q   <= '0;
          idx   <= '0;
          rdy_q <= 1'b0;
        end
        DRAW: if (accept) begin
          w_q[idx] <= cand;
          idx      <= idx + 2'd1;
          if (last_slot) rdy_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign W1        = w_q[0];
  assign W2        = w_q[1];
  assign W3        = w_q[2];
  assign W4        = w_q[3];
  assign SYSRDY    = rdy_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_lottery_draw.sv
// Bench for lottery_draw: four instances (default seed, zero-first seed, duplicate seed, MAX_NUM=20).
module tb_lottery_draw;
  localparam int ND = 4;

  typedef struct {
    int          dut;
    logic [19:0] w;      // {W4,W3,W2,W1}
    int          draws;  // DRAW cycles before FIN
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [ND-1:0] start_v, busy_v, done_v, rdy_v;
  logic [ND-1:0][3:0][4:0] wv;
  logic [ND-1:0][1:0] st_v;
  logic [15:0] m_lfsr [ND];
  logic [19:0] exp_q[$];
  int lat_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl [4];

  always #5 clk = ~clk;

  lottery_draw #(.NUM_W(5), .MAX_NUM(31), .SEED(16'hACE1)) dut_a (
    .CLK(clk), .RST(rst), .START(start_v[0]), .W1(wv[0][0]), .W2(wv[0][1]), .W3(wv[0][2]), .W4(wv[0][3]),
    .BUSY(busy_v[0]), .DONE(done_v[0]), .SYSRDY(rdy_v[0]), .dbg_state(st_v[0]));
  lottery_draw #(.NUM_W(5), .MAX_NUM(31), .SEED(16'h00C0)) dut_b (
    .CLK(clk), .RST(rst), .START(start_v[1]), .W1(wv[1][0]), .W2(wv[1][1]), .W3(wv[1][2]), .W4(wv[1][3]),
    .BUSY(busy_v[1]), .DONE(done_v[1]), .SYSRDY(rdy_v[1]), .dbg_state(st_v[1]));
  lottery_draw #(.NUM_W(5), .MAX_NUM(31), .SEED(16'h007F)) dut_c (
    .CLK(clk), .RST(rst), .START(start_v[2]), .W1(wv[2][0]), .W2(wv[2][1]), .W3(wv[2][2]), .W4(wv[2][3]),
    .BUSY(busy_v[2]), .DONE(done_v[2]), .SYSRDY(rdy_v[2]), .dbg_state(st_v[2]));
  lottery_draw #(.NUM_W(5), .MAX_NUM(20), .SEED(16'hACE1)) dut_d (
    .CLK(clk), .RST(rst), .START(start_v[3]), .W1(wv[3][0]), .W2(wv[3][1]), .W3(wv[3][2]), .W4(wv[3][3]),
    .BUSY(busy_v[3]), .DONE(done_v[3]), .SYSRDY(rdy_v[3]), .dbg_state(st_v[3]));

  function automatic logic [15:0] seed_of(input int d);
    case (d)
      1:       seed_of = 16'h00C0;
      2:       seed_of = 16'h007F;
      default: seed_of = 16'hACE1;
    endcase
  endfunction

  function automatic logic [15:0] lstep(input logic [15:0] l);
    lstep = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // Reference draw: 'now' is the LFSR value at the START edge.
  function automatic void model(input logic [15:0] now, input int maxn,
                                output logic [19:0] w, output int draws);
    logic [15:0] l;
    logic [4:0] c;
    logic [4:0] got [4];
    logic ok;
    int n;
    l = lstep(now);
    n = 0;
    draws = 0;
    for (int k = 0; k < 4; k++) got[k] = '0;
    while (n < 4 && draws < 1000) begin
      c = l[4:0];
      ok = (c != 5'd0) && (int'(c) <= maxn);
      for (int k = 0; k < n; k++) if (got[k] == c) ok = 1'b0;
      if (ok) begin
        got[n] = c;
        n++;
      end
      draws++;
      l = lstep(l);
    end
    w = {got[3], got[2], got[1], got[0]};
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < ND; d++) m_lfsr[d] <= rst ? seed_of(d) : lstep(m_lfsr[d]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input int d);
    chk("rst_w", 32'(wv[d]), 0);
    chk("rst_busy", 32'(busy_v[d]), 0);
    chk("rst_done", 32'(done_v[d]), 0);
    chk("rst_sysrdy", 32'(rdy_v[d]), 0);
  endtask

  task automatic reset_seq();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Caller has START already high; waits (bounded) for DONE at a negedge.
  task automatic wait_done(input int d, input int hold, input int pulse_at, output int busy_n);
    int cyc;
    cyc = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == pulse_at) start_v[d] = 1'b1;
      else if (cyc >= hold) start_v[d] = 1'b0;
      if (cyc == 1) chk("sysrdy_cleared", 32'(rdy_v[d]), 0);
      if (busy_v[d]) busy_n++;
    end while (!done_v[d] && cyc < 200);
    chk("done_seen", 32'(done_v[d]), 1);
  endtask

  // Called at a negedge with the DUT in IDLE; ends one negedge after DONE.
  task automatic do_draw(input int d, input int hold, input int pulse_at,
                         input logic [19:0] ew, input int ed);
    int bn;
    int el;
    logic [19:0] e;
    exp_q.push_back(ew);
    lat_q.push_back(ed);
    start_v[d] = 1'b1;
    wait_done(d, hold, pulse_at, bn);
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    chk("w_at_done", 32'(wv[d]), 32'(e));
    chk("draw_cycles", 32'(bn), 32'(el));
    chk("sysrdy_at_done", 32'(rdy_v[d]), 1);
    chk("busy_at_done", 32'(busy_v[d]), 0);
    start_v[d] = 1'b0;
    @(negedge clk);
    chk("done_single", 32'(done_v[d]), 0);
    chk("sysrdy_hold", 32'(rdy_v[d]), 1);
    chk("w_hold", 32'(wv[d]), 32'(e));
    chk("idle_busy", 32'(busy_v[d]), 0);
  endtask

  function automatic logic inv_ok(input logic [19:0] w, input int maxn);
    logic [4:0] v [4];
    inv_ok = 1'b1;
    for (int k = 0; k < 4; k++) v[k] = w[5*k +: 5];
    for (int k = 0; k < 4; k++) begin
      if (v[k] == 5'd0 || int'(v[k]) > maxn) inv_ok = 1'b0;
      for (int j = k + 1; j < 4; j++) if (v[k] == v[j]) inv_ok = 1'b0;
    end
  endfunction

  initial begin
    logic [19:0] mw;
    int md;
    int bn;
    rst = 1'b0;
    start_v = '0;
    tbl[0] = '{0, {5'd14, 5'd28, 5'd24, 5'd16}, 4};
    tbl[1] = '{1, {5'd6, 5'd12, 5'd24, 5'd16}, 5};   // first candidate is zero
    tbl[2] = '{2, {5'd3, 5'd7, 5'd15, 5'd31}, 5};    // second candidate repeats W1
    tbl[3] = '{0, {5'd14, 5'd28, 5'd24, 5'd16}, 4};

    // Asynchronous reset before any clock edge
    #3 rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) chk_zero(d);
    chk("rst_state", 32'(st_v[0]), 0);
    chk("lfsr_seed", 32'(dut_a.u_lfsr.q), 32'h0000ACE1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("lfsr_step", 32'(dut_a.u_lfsr.q), 32'h00005670);
    chk("idle_no_start", 32'(busy_v[0]), 0);

    // Directed table; START high on the first edge after reset
    for (int i = 0; i < 4; i++) begin
      reset_seq();
      do_draw(tbl[i].dut, 1, 0, tbl[i].w, tbl[i].draws);
    end

    // START pulsed during DRAW must not restart or re-clear
    reset_seq();
    do_draw(0, 1, 2, tbl[0].w, tbl[0].draws);
    @(negedge clk);
    chk("no_redraw", 32'(busy_v[0]), 0);

    // START held: back-to-back draws with one IDLE edge between
    reset_seq();
    model(m_lfsr[0], 31, mw, md);
    start_v[0] = 1'b1;
    wait_done(0, 1000, 0, bn);
    chk("held_w1", 32'(wv[0]), 32'(mw));
    chk("held_cycles1", 32'(bn), 32'(md));
    @(negedge clk);
    chk("held_idle_rdy", 32'(rdy_v[0]), 1);
    chk("held_idle_busy", 32'(busy_v[0]), 0);
    model(m_lfsr[0], 31, mw, md);
    @(negedge clk);
    chk("held_rdy_drop", 32'(rdy_v[0]), 0);
    chk("held_busy2", 32'(busy_v[0]), 1);
    chk("held_cleared", 32'(wv[0]), 0);
    wait_done(0, 1, 0, bn);
    chk("held_w2", 32'(wv[0]), 32'(mw));
    chk("held_cycles2", 32'(bn), 32'(md - 1));
    start_v[0] = 1'b0;
    @(negedge clk);

    // Reset after W2 is stored, then a fresh draw from idx 0
    reset_seq();
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_w2_stored", 32'(wv[0][1]), 24);
    rst = 1'b1;
    #1;
    chk_zero(0);
    @(negedge clk);
    rst = 1'b0;
    do_draw(0, 1, 0, tbl[0].w, tbl[0].draws);

    // MAX_NUM=20 instance, random spacing and START hold length
    reset_seq();
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      model(m_lfsr[3], 20, mw, md);
      do_draw(3, $urandom_range(1, 3), 0, mw, md);
      chk("max20_invariant", 32'(inv_ok(wv[3], 20) & rdy_v[3]), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
